// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit and the datapath muxes it drives.
// Opcode classification helpers are kept here so decode and sequencing agree.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StIf    = 4'b0000,
    StId    = 4'b0001,
    StExeBr = 4'b0010,
    StMem   = 4'b0011,
    StWbL   = 4'b0100,
    StExeB  = 4'b0101,
    StExeA  = 4'b0110,
    StWbA   = 4'b0111,
    StHalt  = 4'b1000
  } state_e;

  localparam logic [5:0] OpAdd  = 6'b000000;
  localparam logic [5:0] OpSub  = 6'b000001;
  localparam logic [5:0] OpAddi = 6'b000010;
  localparam logic [5:0] OpOr   = 6'b010000;
  localparam logic [5:0] OpAnd  = 6'b010001;
  localparam logic [5:0] OpOri  = 6'b010010;
  localparam logic [5:0] OpSlt  = 6'b100110;
  localparam logic [5:0] OpSw   = 6'b110000;
  localparam logic [5:0] OpLw   = 6'b110001;
  localparam logic [5:0] OpBeq  = 6'b110100;
  localparam logic [5:0] OpJ    = 6'b111000;
  localparam logic [5:0] OpJr   = 6'b111001;
  localparam logic [5:0] OpJal  = 6'b111010;
  localparam logic [5:0] OpHalt = 6'b111111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluOr  = 3'b010;
  localparam logic [2:0] AluAnd = 3'b011;
  localparam logic [2:0] AluSlt = 3'b100;

  localparam logic [1:0] PcSrcSeq    = 2'b00;
  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcReg    = 2'b10;
  localparam logic [1:0] PcSrcJump   = 2'b11;

  localparam logic [1:0] RegDstRa = 2'b00;
  localparam logic [1:0] RegDstRt = 2'b01;
  localparam logic [1:0] RegDstRd = 2'b10;

  function automatic logic is_rtype(logic [5:0] op);
    return (op == OpAdd) || (op == OpSub) || (op == OpOr) || (op == OpAnd) || (op == OpSlt);
  endfunction

  function automatic logic is_itype(logic [5:0] op);
    return (op == OpAddi) || (op == OpOri);
  endfunction

  function automatic logic is_alu(logic [5:0] op);
    return is_rtype(op) || is_itype(op);
  endfunction

  function automatic logic is_defined(logic [5:0] op);
    return is_alu(op) || (op == OpSw) || (op == OpLw) || (op == OpBeq) || (op == OpJ) ||
           (op == OpJr) || (op == OpJal) || (op == OpHalt);
  endfunction

  function automatic logic [2:0] alu_op(logic [5:0] op);
    logic [2:0] r;
    case (op)
      OpSub:        r = AluSub;
      OpOr, OpOri:  r = AluOr;
      OpAnd:        r = AluAnd;
      OpSlt:        r = AluSlt;
      default:      r = AluAdd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational datapath-control decode from (state, opcode, zero).
// Every output defaults to 0 so only the asserted fields appear per state.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       InsMemRW,
  output logic       IRWre,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       DataMemRW,
  output logic       DBDataSrc,
  output logic       WrRegData
);

  always_comb begin
    PCWre     = 1'b0;
    PCSrc     = PcSrcSeq;
    InsMemRW  = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    RegDst    = RegDstRa;
    ALUSrcB   = 1'b0;
    ALUOp     = AluAdd;
    ExtSel    = 1'b0;
    DataMemRW = 1'b0;
    DBDataSrc = 1'b0;
    WrRegData = 1'b0;

    case (state)
      StIf: begin
        InsMemRW = 1'b1;
        IRWre    = 1'b1;
      end
      StId: begin
        case (opcode)
          OpJ: begin
            PCWre = 1'b1;
            PCSrc = PcSrcJump;
          end
          OpJr: begin
            PCWre = 1'b1;
            PCSrc = PcSrcReg;
          end
          OpJal: begin
            PCWre  = 1'b1;
            PCSrc  = PcSrcJump;
            RegWre = 1'b1;
            RegDst = RegDstRa;
          end
          default: begin
            // Unknown opcodes retire here as a nop.
            if (!is_defined(opcode)) PCWre = 1'b1;
          end
        endcase
      end
      StExeA, StWbA: begin
        ALUSrcB = is_itype(opcode);
        ALUOp   = alu_op(opcode);
        ExtSel  = (opcode != OpOri);
        if (state == StWbA) begin
          RegWre    = 1'b1;
          RegDst    = is_rtype(opcode) ? RegDstRd : RegDstRt;
          WrRegData = 1'b1;
          PCWre     = 1'b1;
        end
      end
      StExeBr: begin
        ALUOp  = AluSub;
        ExtSel = 1'b1;
        PCWre  = 1'b1;
        PCSrc  = zero ? PcSrcBranch : PcSrcSeq;
      end
      StExeB, StMem: begin
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        if ((state == StMem) && (opcode == OpSw)) begin
          DataMemRW = 1'b1;
          PCWre     = 1'b1;
        end
      end
      StWbL: begin
        RegWre    = 1'b1;
        RegDst    = RegDstRt;
        WrRegData = 1'b1;
        DBDataSrc = 1'b1;
        PCWre     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle CPU control: state register and phase sequencing; output decode lives in
// mc_ctrl_decode. Reset aborts any instruction in flight and returns to fetch.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       InsMemRW,
  output logic       IRWre,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       DataMemRW,
  output logic       DBDataSrc,
  output logic       WrRegData,
  output logic [3:0] state
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIf;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = StIf;
    case (state_q)
      StIf: state_d = StId;
      StId: begin
        if (is_alu(opcode)) begin
          state_d = StExeA;
        end else begin
          case (opcode)
            OpBeq:       state_d = StExeBr;
            OpSw, OpLw:  state_d = StExeB;
            OpHalt:      state_d = StHalt;
            default:     state_d = StIf;
          endcase
        end
      end
      StExeA: state_d = StWbA;
      StExeB: state_d = StMem;
      StMem:  state_d = (opcode == OpLw) ? StWbL : StIf;
      StHalt: state_d = StHalt;
      default: state_d = StIf;
    endcase
  end

  assign state = state_q;

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .zero      (zero),
    .PCWre     (PCWre),
    .PCSrc     (PCSrc),
    .InsMemRW  (InsMemRW),
    .IRWre     (IRWre),
    .RegWre    (RegWre),
    .RegDst    (RegDst),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ExtSel    (ExtSel),
    .DataMemRW (DataMemRW),
    .DBDataSrc (DBDataSrc),
    .WrRegData (WrRegData)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed instruction sequences plus random instruction mix,
// checked cycle by cycle against a phase-path and control-word model of the instruction set.
module tb_mc_control_fsm;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010, OR = 6'b010000;
  localparam logic [5:0] AND = 6'b010001, ORI = 6'b010010, SLT = 6'b100110, SW = 6'b110000;
  localparam logic [5:0] LW = 6'b110001, BEQ = 6'b110100, J = 6'b111000, JR = 6'b111001;
  localparam logic [5:0] JAL = 6'b111010, HALT = 6'b111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       PCWre, InsMemRW, IRWre, RegWre, ALUSrcB, ExtSel, DataMemRW, DBDataSrc, WrRegData;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp;
  logic [3:0] state;
  logic [15:0] dut_out;

  int tests = 0;
  int fails = 0;
  int pcw_seen = 0;
  logic [3:0] path [8];
  int plen = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .PCWre     (PCWre),
    .PCSrc     (PCSrc),
    .InsMemRW  (InsMemRW),
    .IRWre     (IRWre),
    .RegWre    (RegWre),
    .RegDst    (RegDst),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ExtSel    (ExtSel),
    .DataMemRW (DataMemRW),
    .DBDataSrc (DBDataSrc),
    .WrRegData (WrRegData),
    .state     (state)
  );

  assign dut_out = {PCWre, PCSrc, InsMemRW, IRWre, RegWre, RegDst, ALUSrcB, ALUOp, ExtSel,
                    DataMemRW, DBDataSrc, WrRegData};

  function automatic logic rtype(logic [5:0] op);
    return op == ADD || op == SUB || op == OR || op == AND || op == SLT;
  endfunction

  function automatic logic itype(logic [5:0] op);
    return op == ADDI || op == ORI;
  endfunction

  function automatic logic known(logic [5:0] op);
    return rtype(op) || itype(op) || op == SW || op == LW || op == BEQ || op == J ||
           op == JR || op == JAL || op == HALT;
  endfunction

  // Expected control word for one cycle, written field by field from the ISA phase rules.
  function automatic logic [15:0] exp_out(logic [3:0] st, logic [5:0] op, logic z);
    logic pcw = 0, imr = 0, irw = 0, rw = 0, asb = 0, ext = 0, dmw = 0, dbs = 0, wrd = 0;
    logic [1:0] src = 0, dst = 0;
    logic [2:0] aop = 0;
    if (op == SUB) aop = 3'd1;
    else if (op == OR || op == ORI) aop = 3'd2;
    else if (op == AND) aop = 3'd3;
    else if (op == SLT) aop = 3'd4;
    if (st == 4'd0) begin
      imr = 1; irw = 1;
    end else if (st == 4'd1) begin
      if (op == J) begin pcw = 1; src = 2'd3; end
      else if (op == JR) begin pcw = 1; src = 2'd2; end
      else if (op == JAL) begin pcw = 1; src = 2'd3; rw = 1; dst = 2'd0; wrd = 0; end
      else if (!known(op)) pcw = 1;
    end else if (st == 4'd6 || st == 4'd7) begin
      asb = itype(op);
      ext = (op != ORI);
      if (st == 4'd7) begin
        rw = 1; dst = rtype(op) ? 2'd2 : 2'd1; wrd = 1; pcw = 1;
      end
    end else if (st == 4'd2) begin
      ext = 1; pcw = 1; src = z ? 2'd1 : 2'd0;
    end else if (st == 4'd5 || st == 4'd3) begin
      asb = 1; ext = 1;
      if (st == 4'd3 && op == SW) begin dmw = 1; pcw = 1; end
    end else if (st == 4'd4) begin
      rw = 1; dst = 2'd1; wrd = 1; dbs = 1; pcw = 1;
    end
    if (!(st == 4'd6 || st == 4'd7 || st == 4'd2)) aop = 3'd0;
    if (st == 4'd2) aop = 3'd1;
    return {pcw, src, imr, irw, rw, dst, asb, aop, ext, dmw, dbs, wrd};
  endfunction

  function automatic void build_path(logic [5:0] op);
    path[0] = 4'd0; path[1] = 4'd1; plen = 2;
    if (rtype(op) || itype(op)) begin path[2] = 4'd6; path[3] = 4'd7; plen = 4; end
    else if (op == BEQ) begin path[2] = 4'd2; plen = 3; end
    else if (op == SW) begin path[2] = 4'd5; path[3] = 4'd3; plen = 4; end
    else if (op == LW) begin path[2] = 4'd5; path[3] = 4'd3; path[4] = 4'd4; plen = 5; end
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: sample on the falling edge, then return to just after the next rising edge.
  task automatic step(input logic [3:0] st, input string tag);
    @(negedge clk);
    check({tag, "_state"}, {12'd0, state}, {12'd0, st});
    check({tag, "_ctrl"}, dut_out, exp_out(st, opcode, zero));
    pcw_seen += int'(PCWre);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic z, input string tag);
    build_path(op);
    pcw_seen = 0;
    for (int k = 0; k < plen; k++) begin
      opcode = (k == 0) ? 6'($urandom) : op;
      zero = (op == BEQ) ? z : 1'($urandom);
      step(path[k], tag);
    end
    check({tag, "_back_to_if"}, {12'd0, state}, 16'd0);
    check({tag, "_pcwre_count"}, 16'(pcw_seen), 16'd1);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_async_state"}, {12'd0, state}, 16'd0);
    check({tag, "_async_ctrl"}, dut_out, exp_out(4'd0, opcode, zero));
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  logic [5:0] mix [15];

  initial begin
    mix = '{ADD, SUB, ADDI, OR, AND, ORI, SLT, SW, LW, BEQ, J, JR, JAL, 6'b000011, 6'b101010};

    #3 reset = 1'b0;
    #1;
    check("reset_state", {12'd0, state}, 16'd0);
    check("reset_ctrl", dut_out, exp_out(4'd0, opcode, zero));
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", {12'd0, state}, 16'd0);
    reset = 1'b1;

    run_instr(ADD, 1'b0, "add");
    run_instr(BEQ, 1'b1, "beq_taken");
    run_instr(BEQ, 1'b0, "beq_not_taken");
    run_instr(LW, 1'b0, "lw");
    run_instr(SW, 1'b0, "sw");
    run_instr(JAL, 1'b0, "jal");
    run_instr(JR, 1'b0, "jr");
    run_instr(J, 1'b0, "j");
    run_instr(ORI, 1'b0, "ori");
    run_instr(6'b001111, 1'b0, "nop");

    // halt parks the FSM until reset
    opcode = 6'($urandom);
    step(4'd0, "halt");
    opcode = HALT;
    step(4'd1, "halt");
    pcw_seen = 0;
    for (int i = 0; i < 20; i++) begin
      opcode = 6'($urandom);
      zero = 1'($urandom);
      step(4'd8, "halt_park");
    end
    check("halt_pcwre_count", 16'(pcw_seen), 16'd0);
    pulse_reset("halt_reset");
    run_instr(SLT, 1'b0, "after_halt");

    // reset during the MEM phase of lw must abort without a register write
    opcode = 6'($urandom);
    step(4'd0, "abort");
    opcode = LW;
    step(4'd1, "abort");
    step(4'd5, "abort");
    @(negedge clk);
    check("abort_in_mem", {12'd0, state}, 16'd3);
    #2 reset = 1'b0;
    #1;
    check("abort_async_state", {12'd0, state}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_held_state", {12'd0, state}, 16'd0);
      check("abort_no_regwre", {15'd0, RegWre}, 16'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_instr(ADDI, 1'b0, "after_abort");

    for (int n = 0; n < 40; n++) begin
      run_instr(mix[$urandom_range(14, 0)], 1'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
